// File: rtl/alu_pkg.sv
// Shared constants and decoded-entry layout for the ALU control decoder pipe.
// ALU_DEC_MULDIV_EN adds the M-extension marker to each decoded entry.
package alu_pkg;

    localparam int ALU_CODE_W = 4;
    localparam int BR_COND_W  = 3;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'b0110;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'b1001;
    localparam logic [ALU_CODE_W-1:0] ALU_MUL  = 4'b1010;
    localparam logic [ALU_CODE_W-1:0] ALU_DIV  = 4'b1011;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [ALU_CODE_W-1:0] code;
        logic                  br_en;
        logic [BR_COND_W-1:0]  br_cond;
        logic                  illegal;
`ifdef ALU_DEC_MULDIV_EN
        logic                  is_md;
`endif
    } dec_entry_t;

endpackage

// File: rtl/alu_dec_comb.sv
// Purely combinational ALU control decode applied to the request at the push side.
// ALU_DEC_MULDIV_EN enables MUL/DIV decode of the R-type M pattern.
module alu_dec_comb
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [6:0] op,
    output dec_entry_t entry
);

    logic [ALU_CODE_W-1:0] code_s;
    logic                  illegal_s;
    logic                  rtype_bad_s;
    logic                  m_pattern_s;
    logic                  br_en_s;

    assign m_pattern_s = (op == OP_RTYPE) && (funct7 == F7_MULDIV);
    // Any op[5] encoding whose funct7 is neither base nor a legal alternate form.
    assign rtype_bad_s = op[5] && (funct7 != F7_BASE)
                         && !((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    assign br_en_s     = (op == OP_BRANCH);

    // ALU code and illegal flag selection.
    always_comb begin
        code_s    = ALU_ADD;
        illegal_s = 1'b0;
        case (alu_op)
            2'b00: code_s = ALU_ADD;
            2'b01: begin
                if (funct3[2:1] == 2'b11) begin
                    code_s = ALU_SLTU;
                end else begin
                    code_s = ALU_SUB;
                end
            end
            2'b10: begin
                case (funct3)
                    3'b000:  code_s = (op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  code_s = ALU_SLL;
                    3'b010:  code_s = ALU_SLT;
                    3'b011:  code_s = ALU_SLTU;
                    3'b100:  code_s = ALU_XOR;
                    3'b101:  code_s = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  code_s = ALU_OR;
                    3'b111:  code_s = ALU_AND;
                    default: code_s = ALU_ADD;
                endcase
            end
            2'b11: begin
                code_s    = ALU_ADD;
                illegal_s = 1'b1;
            end
            default: begin
                code_s    = ALU_ADD;
                illegal_s = 1'b1;
            end
        endcase
        if (m_pattern_s) begin
`ifdef ALU_DEC_MULDIV_EN
            code_s    = funct3[2] ? ALU_DIV : ALU_MUL;
            illegal_s = 1'b0;
`else
            code_s    = ALU_ADD;
            illegal_s = 1'b1;
`endif
        end else begin
            illegal_s = illegal_s | rtype_bad_s;
        end
    end

    assign entry.code    = code_s;
    assign entry.br_en   = br_en_s;
    assign entry.br_cond = br_en_s ? funct3 : 3'b000;
    assign entry.illegal = illegal_s;
`ifdef ALU_DEC_MULDIV_EN
    assign entry.is_md   = m_pattern_s;
`endif

endmodule

// File: rtl/alu_decoder_pipe.sv
// Registered ALU control decoder with a 2-entry head-first skid FIFO.
// ALU_DEC_MULDIV_EN adds a head-wait counter holding M ops for MD_LATENCY cycles.
module alu_decoder_pipe
    import alu_pkg::*;
#(
    parameter int CTRL_W     = 4,
    parameter int MD_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [6:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              br_en,
    output logic [2:0]        br_cond,
    output logic              illegal,
    output logic              md_busy
);

    if ((CTRL_W < 4) || (MD_LATENCY < 1) || (MD_LATENCY > 15)) begin : g_bad_params
        $error("alu_decoder_pipe: CTRL_W must be >= 4 and MD_LATENCY in 1..15");
    end

    dec_entry_t dec_s;
    dec_entry_t head_r;
    dec_entry_t tail_r;
    dec_entry_t head_next_s;
    logic [1:0] count_r;
    logic [1:0] count_next_s;
    logic       push_s;
    logic       pop_s;
    logic       head_load_s;

    alu_dec_comb u_dec (
        .alu_op (alu_op),
        .funct3 (funct3),
        .funct7 (funct7),
        .op     (op),
        .entry  (dec_s)
    );

    assign in_ready = (count_r != 2'd2);
    assign push_s   = in_valid && in_ready;
    assign pop_s    = out_valid && out_ready;

    // Head/count next-state; push-with-pop only happens at count 1 since full blocks push.
    always_comb begin
        head_load_s  = 1'b0;
        head_next_s  = head_r;
        count_next_s = count_r;
        if (push_s && ((count_r == 2'd0) || pop_s)) begin
            head_load_s = 1'b1;
            head_next_s = dec_s;
        end else if (pop_s && (count_r == 2'd2)) begin
            head_load_s = 1'b1;
            head_next_s = tail_r;
        end else begin
            head_load_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            count_r <= count_next_s;
            if (head_load_s) begin
                head_r <= head_next_s;
            end
            if (push_s && !pop_s && (count_r == 2'd1)) begin
                tail_r <= dec_s;
            end
        end
    end

`ifdef ALU_DEC_MULDIV_EN
    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);
    logic [3:0] md_cnt_r;

    // Head-wait countdown, reloaded whenever a new entry reaches the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_r <= 4'd0;
        end else if (head_load_s) begin
            md_cnt_r <= head_next_s.is_md ? MD_LOAD : 4'd0;
        end else if (md_cnt_r != 4'd0) begin
            md_cnt_r <= md_cnt_r - 4'd1;
        end
    end

    assign out_valid = (count_r != 2'd0) && (md_cnt_r == 4'd0);
    assign md_busy   = (count_r != 2'd0) && (md_cnt_r != 4'd0);
`else
    assign out_valid = (count_r != 2'd0);
    assign md_busy   = 1'b0;
`endif

    assign alu_ctrl = CTRL_W'(head_r.code);
    assign br_en    = head_r.br_en;
    assign br_cond  = head_r.br_cond;
    assign illegal  = head_r.illegal;

endmodule
